// File: rtl/instr_prefetch_queue_if.sv
// Bundle of the prefetch queue's bus-side signals.
//   imem_*      : request/response to the 1-cycle-latency instruction memory
//   redirect*   : taken branch/jump target from EX
//   stall       : decode not accepting
//   out_*       : instruction, PC and PC+4 presented to the IF/ID register
// master = the prefetch queue, slave = its environment (imem + pipeline).
interface instr_prefetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, stall
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Fetch-side front end: owns the fetch PC, issues word reads to a 1-cycle
// instruction memory, buffers returned {instr, pc} in a small FIFO and
// presents the head to the IF/ID register.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : synchronous, active-high
//   bus    : instr_prefetch_queue_if.master (imem req/resp, redirect,
//            stall, out_valid/out_instr/out_pc/out_pc4)
module instr_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic                    clk,
  input logic                    reset,
  instr_prefetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             inflight_q, inflight_d;
  logic             epoch_q, epoch_d;
  logic [31:0]      infl_pc_q, infl_pc_d;
  logic             infl_epoch_q, infl_epoch_d;
  logic [31:0]      last_pc_q, last_pc_d;
  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];

  logic        issue_w;
  logic        push_w;
  logic        pop_w;
  logic        head_valid_w;
  logic [31:0] head_instr_w;
  logic [31:0] head_pc_w;
  logic [31:0] out_pc_w;

  assign head_valid_w = (count_q != '0);
  assign head_instr_w = mem_q[rd_ptr_q][63:32];
  assign head_pc_w    = mem_q[rd_ptr_q][31:0];

  // Credit rule: only issue when the response is guaranteed a free slot.
  assign issue_w = !reset && !bus.redirect &&
                   ((count_q + CNT_W'(inflight_q)) < DEPTH_C);

  // Responses from before a redirect carry the old epoch and are dropped;
  // a response landing in the redirect cycle itself is dropped explicitly.
  assign push_w = bus.imem_rvalid && inflight_q &&
                  (infl_epoch_q == epoch_q) && !bus.redirect;

  assign pop_w = head_valid_w && !bus.stall && !bus.redirect;

  assign bus.imem_req  = issue_w;
  assign bus.imem_addr = fetch_pc_q;

  // When empty, out_pc/out_pc4 keep showing the last popped PC.
  assign out_pc_w      = head_valid_w ? head_pc_w : last_pc_q;
  assign bus.out_valid = head_valid_w;
  assign bus.out_instr = head_valid_w ? head_instr_w : NOP_INSTR;
  assign bus.out_pc    = out_pc_w;
  assign bus.out_pc4   = out_pc_w + 32'd4;

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    inflight_d   = inflight_q;
    epoch_d      = epoch_q;
    infl_pc_d    = infl_pc_q;
    infl_epoch_d = infl_epoch_q;
    last_pc_d    = last_pc_q;
    mem_d        = mem_q;

    if (push_w) begin
      mem_d[wr_ptr_q] = {bus.imem_rdata, infl_pc_q};
    end

    if (bus.imem_rvalid) begin
      inflight_d = 1'b0;
    end

    if (bus.redirect) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      epoch_d    = ~epoch_q;
      fetch_pc_d = bus.redirect_pc & ~32'd3;
    end else begin
      if (issue_w) begin
        fetch_pc_d   = fetch_pc_q + 32'd4;
        inflight_d   = 1'b1;
        infl_pc_d    = fetch_pc_q;
        infl_epoch_d = epoch_q;
      end
      if (push_w) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_w) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        last_pc_d = head_pc_w;
      end
      count_d = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      inflight_q   <= 1'b0;
      epoch_q      <= 1'b0;
      infl_pc_q    <= '0;
      infl_epoch_q <= 1'b0;
      last_pc_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      inflight_q   <= inflight_d;
      epoch_q      <= epoch_d;
      infl_pc_q    <= infl_pc_d;
      infl_epoch_q <= infl_epoch_d;
      last_pc_q    <= last_pc_d;
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // A push into a full FIFO means the credit rule was broken.
  always_ff @(posedge clk) begin
    if (!reset && push_w) begin
      assert (count_q < DEPTH_C);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = 32'h0;
  int n_cmp = 0;
  int n_err = 0;

  instr_prefetch_queue_if bus ();

  instr_prefetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // imem model: 1-cycle latency, returns the address as data.
  always @(posedge clk) begin
    mem_rvalid <= bus.imem_req;
    mem_rdata  <= bus.imem_addr;
  end
  assign bus.imem_rvalid = mem_rvalid;
  assign bus.imem_rdata  = mem_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle with reset low).
  task automatic restart(input logic stall_v);
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    tick();
    bus.stall = stall_v;
    reset     = 1'b0;
    settle();
  endtask

  initial begin
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_instr", bus.out_instr, 32'h13);
    chk("rst_pc",    bus.out_pc,    32'h0);
    chk("rst_pc4",   bus.out_pc4,   32'h4);
    chk("rst_req",   32'(bus.imem_req), 32'd0);

    // Free-running stream
    reset = 1'b0;
    settle();
    chk("c0_req",   32'(bus.imem_req),  32'd1);
    chk("c0_addr",  bus.imem_addr,      32'h0);
    chk("c0_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("c1_valid", 32'(bus.out_valid), 32'd0);
    chk("c1_addr",  bus.imem_addr,      32'h4);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_pc",    bus.out_pc,    32'(4 * k));
      chk("stream_instr", bus.out_instr, 32'(4 * k));
      chk("stream_pc4",   bus.out_pc4,   32'(4 * k + 4));
    end

    // Misaligned redirect target
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    settle();
    chk("align_redir_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect = 1'b0;
    settle();
    chk("align_req",  32'(bus.imem_req), 32'd1);
    chk("align_addr", bus.imem_addr,     32'h100);
    tick();
    chk("align_empty", 32'(bus.out_valid), 32'd0);
    tick();
    chk("align_valid", 32'(bus.out_valid), 32'd1);
    chk("align_pc",    bus.out_pc,  32'h100);
    chk("align_pc4",   bus.out_pc4, 32'h104);

    // PC wrap at top of address space
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    settle();
    tick();
    bus.redirect = 1'b0;
    settle();
    chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", bus.imem_addr, 32'h0);
    tick();
    chk("wrap_pc",  bus.out_pc,  32'hFFFF_FFFC);
    chk("wrap_pc4", bus.out_pc4, 32'h0);
    tick();
    chk("wrap_next_pc",  bus.out_pc,  32'h0);
    chk("wrap_next_pc4", bus.out_pc4, 32'h4);

    // Back-to-back redirects: only the last target is fetched
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h300;
    settle();
    chk("b2b_req0", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_pc = 32'h400;
    settle();
    chk("b2b_req1", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect = 1'b0;
    settle();
    chk("b2b_addr", bus.imem_addr, 32'h400);
    tick();
    chk("b2b_empty", 32'(bus.out_valid), 32'd0);
    tick();
    chk("b2b_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_pc",    bus.out_pc, 32'h400);

    // Reset mid-stream while a response is returning
    tick();
    reset = 1'b1;
    settle();
    chk("rmid_req_in_reset", 32'(bus.imem_req), 32'd0);
    tick();
    chk("rmid_valid", 32'(bus.out_valid), 32'd0);
    chk("rmid_instr", bus.out_instr, 32'h13);
    chk("rmid_pc",    bus.out_pc,    32'h0);
    chk("rmid_pc4",   bus.out_pc4,   32'h4);
    chk("rmid_req",   32'(bus.imem_req), 32'd0);
    reset = 1'b0;
    settle();
    chk("rmid_restart_addr", bus.imem_addr, 32'h0);
    chk("rmid_restart_req",  32'(bus.imem_req), 32'd1);
    tick();
    tick();
    chk("rmid_first_valid", 32'(bus.out_valid), 32'd1);
    chk("rmid_first_pc",    bus.out_pc, 32'h0);

    // Stall until full, then drain in order
    restart(1'b1);
    tick(); tick(); tick(); tick();
    chk("full_req_c4", 32'(bus.imem_req), 32'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("full_req_c9",  32'(bus.imem_req),  32'd0);
    chk("full_valid",   32'(bus.out_valid), 32'd1);
    chk("full_head_pc", bus.out_pc, 32'h0);
    tick();
    bus.stall = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk("drain_pc",    bus.out_pc,    32'(4 * k));
      chk("drain_instr", bus.out_instr, 32'(4 * k));
      tick();
    end

    // Redirect with 3 queued and 1 in flight
    restart(1'b1);
    tick(); tick(); tick(); tick();
    chk("pre_redir_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_redir_pc",    bus.out_pc, 32'h0);
    bus.stall       = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    settle();
    chk("flush_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect = 1'b0;
    settle();
    chk("flush_empty1", 32'(bus.out_valid), 32'd0);
    chk("flush_addr",   bus.imem_addr, 32'h100);
    tick();
    chk("flush_empty2", 32'(bus.out_valid), 32'd0);
    tick();
    chk("flush_valid", 32'(bus.out_valid), 32'd1);
    chk("flush_pc",    bus.out_pc, 32'h100);
    tick();
    chk("flush_pc_next", bus.out_pc, 32'h104);

    // Redirect while stalled and a response returns
    restart(1'b1);
    tick(); tick(); tick(); tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    settle();
    chk("sr_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect = 1'b0;
    settle();
    chk("sr_empty1", 32'(bus.out_valid), 32'd0);
    chk("sr_addr",   bus.imem_addr, 32'h200);
    tick();
    chk("sr_empty2", 32'(bus.out_valid), 32'd0);
    tick();
    chk("sr_valid", 32'(bus.out_valid), 32'd1);
    chk("sr_pc",    bus.out_pc, 32'h200);
    tick();
    chk("sr_hold_pc", bus.out_pc, 32'h200);
    bus.stall = 1'b0;
    settle();
    tick();
    chk("sr_next_pc", bus.out_pc, 32'h204);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
